// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - shared state encodings and frame constants for the serial tx/rx pair
package usrt_pkg;

   localparam int DATA_BITS = 8;
   localparam int BAUD_MIN  = 2;

   typedef enum logic [2:0] {
      s_IDLE   = 3'd0,
      s_START  = 3'd1,
      s_DATA   = 3'd2,
      s_STOP   = 3'd3,
      s_FINISH = 3'd4
   } state_t;

   // Baud values below BAUD_MIN are clamped so a bit always spans at least two clocks.
   function automatic logic [7:0] eff_baud(input logic [7:0] baud);
      return (baud < 8'(BAUD_MIN)) ? 8'(BAUD_MIN) : baud;
   endfunction

endpackage

// File: rtl/rx_sync2.sv
// rtl/rx_sync2.sv - two-flop synchroniser for the serial line, resets to the idle (high) level
module rx_sync2 (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_D,
   output logic o_Q
);

   logic r_Meta;
   logic r_Sync;

   // Two-stage capture of the asynchronous line; both stages reset to idle-high.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Meta <= 1'b1;
         r_Sync <= 1'b1;
      end else begin
         r_Meta <= i_D;
         r_Sync <= r_Meta;
      end
   end

   assign o_Q = r_Sync;

endmodule

// File: rtl/rxshift.sv
// rtl/rxshift.sv - receive shift register, mid-bit sampling; RXSHIFT_SYNC_EN adds a 2-flop line synchroniser
module rxshift #(
   parameter int DATA_BITS = usrt_pkg::DATA_BITS
) (
   input  logic                 i_Pclk,
   input  logic                 i_Reset,
   input  logic [7:0]           i_Baud,
   input  logic                 i_Enable,
   input  logic                 i_Rx_Serial,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Pready,
   output logic                 o_Frame_Err
);

   import usrt_pkg::*;

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   state_t               r_State;
   state_t               w_State_Nxt;
   logic [7:0]           r_Count;
   logic [7:0]           w_Count_Nxt;
   logic [IDX_W-1:0]     r_Index;
   logic [IDX_W-1:0]     w_Index_Nxt;
   logic [DATA_BITS-1:0] r_Shift;
   logic [DATA_BITS-1:0] w_Shift_Nxt;
   logic [DATA_BITS-1:0] r_Data;
   logic [DATA_BITS-1:0] w_Data_Nxt;
   logic                 r_Pready;
   logic                 w_Pready_Nxt;
   logic                 r_Frame_Err;
   logic                 w_Frame_Err_Nxt;
   logic                 r_Armed;
   logic                 w_Armed_Nxt;

   logic                 w_Rx;
   logic [7:0]           w_Baud;
   logic [7:0]           w_Baud_M1;
   logic [7:0]           w_Half_M1;

`ifdef RXSHIFT_SYNC_EN
   rx_sync2 u_rx_sync2 (
      .i_Clk   (i_Pclk),
      .i_Reset (i_Reset),
      .i_D     (i_Rx_Serial),
      .o_Q     (w_Rx)
   );
`else
   assign w_Rx = i_Rx_Serial;
`endif

   assign w_Baud    = eff_baud(i_Baud);
   assign w_Baud_M1 = w_Baud - 8'd1;
   assign w_Half_M1 = (w_Baud >> 1) - 8'd1;

   // Next-state and datapath decode; every target starts from its held value.
   always_comb begin
      w_State_Nxt     = r_State;
      w_Count_Nxt     = r_Count;
      w_Index_Nxt     = r_Index;
      w_Shift_Nxt     = r_Shift;
      w_Data_Nxt      = r_Data;
      w_Pready_Nxt    = 1'b0;
      w_Frame_Err_Nxt = r_Frame_Err;
      w_Armed_Nxt     = r_Armed;

      case (r_State)
         s_IDLE: begin
            w_Count_Nxt = 8'd0;
            w_Index_Nxt = '0;
            if (w_Rx) begin
               w_Armed_Nxt = 1'b1;
            end
            if (i_Enable && r_Armed && !w_Rx) begin
               w_State_Nxt = s_START;
            end
         end
         s_START: begin
            if (r_Count >= w_Half_M1) begin
               w_Count_Nxt = 8'd0;
               // A high line at mid-start means a glitch, not a frame.
               w_State_Nxt = w_Rx ? s_IDLE : s_DATA;
            end else begin
               w_Count_Nxt = r_Count + 8'd1;
            end
         end
         s_DATA: begin
            if (r_Count >= w_Baud_M1) begin
               w_Count_Nxt          = 8'd0;
               w_Shift_Nxt[r_Index] = w_Rx;
               if (r_Index == IDX_W'(DATA_BITS - 1)) begin
                  w_Index_Nxt = '0;
                  w_State_Nxt = s_STOP;
               end else begin
                  w_Index_Nxt = r_Index + 1'b1;
               end
            end else begin
               w_Count_Nxt = r_Count + 8'd1;
            end
         end
         s_STOP: begin
            if (r_Count >= w_Baud_M1) begin
               w_Count_Nxt  = 8'd0;
               w_Pready_Nxt = 1'b1;
               w_State_Nxt  = s_FINISH;
               if (w_Rx) begin
                  w_Data_Nxt      = r_Shift;
                  w_Frame_Err_Nxt = 1'b0;
               end else begin
                  // Bad stop bit: keep the last good byte and disarm until the line idles high.
                  w_Frame_Err_Nxt = 1'b1;
                  w_Armed_Nxt     = 1'b0;
               end
            end else begin
               w_Count_Nxt = r_Count + 8'd1;
            end
         end
         s_FINISH: begin
            w_Count_Nxt = 8'd0;
            w_State_Nxt = s_IDLE;
            if (r_Frame_Err) begin
               w_Armed_Nxt = 1'b0;
            end
         end
         default: begin
            w_Count_Nxt = 8'd0;
            w_Index_Nxt = '0;
            w_State_Nxt = s_IDLE;
         end
      endcase

      // Disabling mid-frame abandons the frame without touching the presented result.
      if (!i_Enable && (r_State != s_IDLE)) begin
         w_State_Nxt     = s_IDLE;
         w_Count_Nxt     = 8'd0;
         w_Index_Nxt     = '0;
         w_Pready_Nxt    = 1'b0;
         w_Data_Nxt      = r_Data;
         w_Frame_Err_Nxt = r_Frame_Err;
         w_Armed_Nxt     = r_Armed;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_State     <= s_IDLE;
         r_Count     <= 8'd0;
         r_Index     <= '0;
         r_Shift     <= '0;
         r_Data      <= '0;
         r_Pready    <= 1'b0;
         r_Frame_Err <= 1'b0;
         r_Armed     <= 1'b0;
      end else begin
         r_State     <= w_State_Nxt;
         r_Count     <= w_Count_Nxt;
         r_Index     <= w_Index_Nxt;
         r_Shift     <= w_Shift_Nxt;
         r_Data      <= w_Data_Nxt;
         r_Pready    <= w_Pready_Nxt;
         r_Frame_Err <= w_Frame_Err_Nxt;
         r_Armed     <= w_Armed_Nxt;
      end
   end

   assign o_Data      = r_Data;
   assign o_Pready    = r_Pready;
   assign o_Frame_Err = r_Frame_Err;

endmodule

// File: tb/tb_rxshift.sv
// tb/tb_rxshift.sv - directed bench for rxshift with hand-computed frames
module tb_rxshift;

   logic       i_Pclk = 1'b0;
   logic       i_Reset = 1'b1;
   logic [7:0] i_Baud = 8'd8;
   logic       i_Enable = 1'b0;
   logic       i_Rx_Serial = 1'b1;
   logic [7:0] o_Data;
   logic       o_Pready;
   logic       o_Frame_Err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int pulses = 0;
   int wide = 0;
   int last_pcyc = 0;
   int p0 = 0;
   logic prev_pready = 1'b0;

`ifdef RXSHIFT_SYNC_EN
   localparam int LAT = 78;
`else
   localparam int LAT = 76;
`endif

   rxshift dut (
      .i_Pclk      (i_Pclk),
      .i_Reset     (i_Reset),
      .i_Baud      (i_Baud),
      .i_Enable    (i_Enable),
      .i_Rx_Serial (i_Rx_Serial),
      .o_Data      (o_Data),
      .o_Pready    (o_Pready),
      .o_Frame_Err (o_Frame_Err)
   );

   always #5 i_Pclk = ~i_Pclk;

   always @(posedge i_Pclk) cyc <= cyc + 1;

   always @(negedge i_Pclk) begin
      if (o_Pready) begin
         pulses    = pulses + 1;
         last_pcyc = cyc;
      end
      if (o_Pready && prev_pready) wide = wide + 1;
      prev_pready = o_Pready;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge i_Pclk);
         #1;
      end
   endtask

   // act: 0 none, 1 drop enable, 2 pulse reset; applied at the start of data bit act_bit.
   task automatic send_frame(input logic [7:0] d, input int b, input logic stop_v,
                             input int act_bit, input int act);
      logic [9:0] f;
      f = {stop_v, d, 1'b0};
      @(posedge i_Pclk);
      #1;
      t0 = cyc + 1;
      for (int i = 0; i < 10; i++) begin
         i_Rx_Serial = f[i];
         for (int c = 0; c < b; c++) begin
            if (i == act_bit + 1 && c == 0 && act == 1) i_Enable = 1'b0;
            if (i == act_bit + 1 && c == 0 && act == 2) i_Reset = 1'b1;
            @(posedge i_Pclk);
            #1;
            if (i_Reset) begin
               chk("midreset_data", 32'(o_Data), 32'h00);
               chk("midreset_pready", 32'(o_Pready), 32'h0);
               chk("midreset_ferr", 32'(o_Frame_Err), 32'h0);
               i_Reset = 1'b0;
            end
         end
      end
   endtask

   initial begin
      wait_cycles(3);
      chk("reset_data", 32'(o_Data), 32'h00);
      chk("reset_pready", 32'(o_Pready), 32'h0);
      chk("reset_ferr", 32'(o_Frame_Err), 32'h0);
      i_Reset  = 1'b0;
      i_Enable = 1'b1;
      wait_cycles(10);

      // Single frame 0xA5 at 8 clocks/bit, with latency check.
      p0 = pulses;
      send_frame(8'hA5, 8, 1'b1, -1, 0);
      i_Rx_Serial = 1'b1;
      wait_cycles(6);
      chk("a5_pulses", 32'(pulses), 32'(p0 + 1));
      chk("a5_data", 32'(o_Data), 32'hA5);
      chk("a5_ferr", 32'(o_Frame_Err), 32'h0);
      chk("a5_latency", 32'(last_pcyc - t0), 32'(LAT));

      // Back-to-back 0x00 then 0xFF at 16 clocks/bit.
      i_Baud = 8'd16;
      p0 = pulses;
      send_frame(8'h00, 16, 1'b1, -1, 0);
      i_Rx_Serial = 1'b1;
      chk("b2b_first_data", 32'(o_Data), 32'h00);
      chk("b2b_first_pulses", 32'(pulses), 32'(p0 + 1));
      send_frame(8'hFF, 16, 1'b1, -1, 0);
      i_Rx_Serial = 1'b1;
      wait_cycles(6);
      chk("b2b_second_data", 32'(o_Data), 32'hFF);
      chk("b2b_pulses", 32'(pulses), 32'(p0 + 2));

      // Two-cycle low glitch in IDLE is a false start.
      i_Baud = 8'd8;
      p0 = pulses;
      i_Rx_Serial = 1'b0;
      wait_cycles(2);
      i_Rx_Serial = 1'b1;
      wait_cycles(30);
      chk("glitch_pulses", 32'(pulses), 32'(p0));
      chk("glitch_data", 32'(o_Data), 32'hFF);

      // Framing error, line then stuck low.
      p0 = pulses;
      send_frame(8'h3C, 8, 1'b0, -1, 0);
      chk("ferr_pulses", 32'(pulses), 32'(p0 + 1));
      chk("ferr_flag", 32'(o_Frame_Err), 32'h1);
      chk("ferr_data_kept", 32'(o_Data), 32'hFF);
      wait_cycles(40);
      chk("stuck_low_no_retrigger", 32'(pulses), 32'(p0 + 1));
      i_Rx_Serial = 1'b1;
      wait_cycles(10);
      chk("ferr_held", 32'(o_Frame_Err), 32'h1);
      send_frame(8'h3C, 8, 1'b1, -1, 0);
      i_Rx_Serial = 1'b1;
      wait_cycles(6);
      chk("recover_data", 32'(o_Data), 32'h3C);
      chk("recover_ferr", 32'(o_Frame_Err), 32'h0);
      chk("recover_pulses", 32'(pulses), 32'(p0 + 2));

      // Enable dropped at data bit 3.
      p0 = pulses;
      send_frame(8'hF8, 8, 1'b1, 3, 1);
      i_Rx_Serial = 1'b1;
      wait_cycles(20);
      i_Enable = 1'b1;
      wait_cycles(10);
      chk("disable_pulses", 32'(pulses), 32'(p0));
      chk("disable_data", 32'(o_Data), 32'h3C);

      // Reset pulsed at data bit 3.
      p0 = pulses;
      send_frame(8'hF8, 8, 1'b1, 3, 2);
      i_Rx_Serial = 1'b1;
      wait_cycles(20);
      chk("reset_mid_pulses", 32'(pulses), 32'(p0));
      chk("reset_mid_data", 32'(o_Data), 32'h00);

      // Baud 0, 1 and 2 all mean 2 clocks per bit.
      for (int k = 0; k < 3; k++) begin
         i_Baud = 8'(k);
         wait_cycles(5);
         p0 = pulses;
         send_frame(8'h5A, 2, 1'b1, -1, 0);
         i_Rx_Serial = 1'b1;
         wait_cycles(6);
         chk($sformatf("baud%0d_5a", k), 32'(o_Data), 32'h5A);
         send_frame(8'hA5, 2, 1'b1, -1, 0);
         i_Rx_Serial = 1'b1;
         wait_cycles(6);
         chk($sformatf("baud%0d_a5", k), 32'(o_Data), 32'hA5);
         chk($sformatf("baud%0d_pulses", k), 32'(pulses), 32'(p0 + 2));
      end

      chk("pulse_width", 32'(wide), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rxshift.md
Name: rxshift

Overview:
- Receive shift register: the receive-side counterpart of the txshift serial transmitter. Both blocks share the same frame format and the same per-bit clock count, i_Baud.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Oversamples the serial line on i_Pclk and samples each bit at mid-bit.
- Presents the assembled byte to the APB-side logic with a one-cycle o_Pready pulse.

Parameters:
- DATA_BITS, 8, data bits per frame; the index counter width is clog2(DATA_BITS).

Ports:
- i_Pclk  input  1  system clock; all logic on posedge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Baud  input  8  i_Pclk cycles per bit. Values 0 and 1 are treated as 2.
- i_Enable  input  1  receiver enable. Low forces IDLE.
- i_Rx_Serial  input  1  serial line, idles high.
- o_Data  output  8  last correctly framed byte. Held until the next good frame.
- o_Pready  output  1  one-cycle pulse at end of every completed frame.
- o_Frame_Err  output  1  valid while o_Pready=1. 1 means the stop bit was sampled as 0.

Behaviour:
- Reset (i_Reset=1 at posedge):
  - State=IDLE; counters=0; shift register=0.
  - o_Data=0x00, o_Pready=0, o_Frame_Err=0.
  - Reset overrides everything, including mid-frame.
- Definitions:
  - rx = i_Rx_Serial, or its synchronised copy; see Optional Feature.
  - B = max(i_Baud, 2).
  - H = B>>1.
  - Clock counter is 8 bits and never exceeds B-1.
- States:
  - IDLE:
    - Counter=0, index=0, o_Pready=0.
    - If i_Enable & r_Armed & rx==0, go to START.
    - r_Armed sets whenever rx==1 is seen in IDLE. It clears on leaving FINISH with a framing error.
    - This blocks retrigger on a stuck-low line.
  - START:
    - Count up. At count==H-1, sample rx.
    - rx==1: false start; go to IDLE, no pulse.
    - rx==0: counter=0; go to DATA.
  - DATA:
    - Count up. At count==B-1, write shift[index] <= rx and reset the counter.
    - After index DATA_BITS-1, go to STOP; otherwise index++.
  - STOP:
    - At count==B-1, sample rx.
    - rx==1: o_Data <= shift, o_Frame_Err <= 0.
    - rx==0: o_Data unchanged, o_Frame_Err <= 1, r_Armed <= 0.
    - Either case: o_Pready <= 1; go to FINISH.
  - FINISH: o_Pready <= 0; go to IDLE. Total pulse width is exactly 1 cycle.
  - Default/illegal state: go to IDLE.
- Latency (no sync, B=8, line low first seen in IDLE at cycle t0):
  - Start sampled at t0+4.
  - Data bit k sampled at t0+12+8k.
  - Stop bit sampled at t0+76.
  - o_Pready high during cycle t0+77.
- i_Enable low in any non-IDLE state: next state IDLE, counters cleared, no pulse, o_Data unchanged.
- i_Baud changes mid-frame: the new value takes effect at the next compare. Software must not do this.
- o_Frame_Err holds its value after the pulse until the next frame end.

Optional Feature:
- Macro: RXSHIFT_SYNC_EN.
- Defined:
  - i_Rx_Serial passes through a 2-flop synchroniser. The flops reset to 1.
  - rx is the second flop's output; all latencies grow by 2 cycles.
- Undefined:
  - rx = i_Rx_Serial directly. Only legal when the line is generated in the i_Pclk domain (e.g. loopback from txshift).

Decomposition:
- Shared package usrt_pkg:
  - State encodings s_IDLE=0, s_START=1, s_DATA=2, s_STOP=3, s_FINISH=4, common with txshift.
  - Constants DATA_BITS=8 and BAUD_MIN=2.
- Sub-module rx_sync2:
  - 2-flop synchroniser with reset value 1.
  - Instantiated only under RXSHIFT_SYNC_EN.
- Counter/state logic stays in rxshift.

Test Plan:
- Loopback from txshift, i_Baud=8, byte 0xA5 -> o_Data=0xA5, o_Pready high one cycle at t0+77, o_Frame_Err=0.
- Back-to-back frames 0x00 then 0xFF, i_Baud=16 -> two pulses, o_Data 0x00 then 0xFF, no missed or extra pulse.
- 2-cycle low glitch on the line in IDLE, i_Baud=8 -> false start, return to IDLE, no pulse, o_Data unchanged.
- Frame 0x3C with stop bit forced 0, line then held low 40 cycles -> pulse with o_Frame_Err=1, o_Data keeps its old value, no new start until the line returns high.
- i_Enable dropped at data bit 3; i_Reset asserted mid-frame in a separate run -> IDLE next cycle, no pulse, reset outputs 0x00/0/0.
- i_Baud=0 and i_Baud=1, byte 0x5A sent at 2 cycles/bit -> received as 0x5A, identical to i_Baud=2.
